id_ex_pipe_reg: RTL and testbench

- Decode-to-Execute pipeline register for the RV64I+Zba 5-stage core.
- Captures decoded operands, immediates, register indices and control bits at the end of Decode.
- Presents them as the *_E signals consumed by the Execute datapath and by the forwarding unit (Rs1_E, Rs2_E).
- Supports stall (hold), flush (bubble insertion), a valid bit and a saturating bubble counter for performance debug.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/pipe_field_reg.sv | 36 +++
 rtl/id_ex_pipe_reg.sv | 161 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the RV64I+Zba 5-stage core:
//               datapath width, writeback select codes, ALU operations and
//               the bundled control word carried down the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN      = 64;
    localparam int ALUCTRL_W = 4;

    // Writeback select encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALU operations; the .uw forms reuse the base op with Word set
    typedef enum logic [ALUCTRL_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_SH1ADD = 4'd10,
        ALU_SH2ADD = 4'd11,
        ALU_SH3ADD = 4'd12,
        ALU_PASSB  = 4'd13
    } alu_ctrl_e;

    // Control bits that travel together from Decode to Execute
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       alu_src;
        alu_ctrl_e  alu_ctrl;
        logic       word;
        logic [2:0] funct3;
    } ctrl_t;

    localparam int    CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_field_reg
// Description : Generic-width pipeline field register with synchronous
//               reset, clear (bubble) and load enable (hold when low).
//               Priority: rst > clear > enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_field_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over hold so a flushed slot never keeps stale contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_field_reg
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : Decode-to-Execute pipeline register. Holds on stall, inserts
//               a zeroed bubble on flush or invalid decode, and keeps a
//               saturating count of bubbles entering Execute.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN         = 64,
    parameter int ALUCTRL_W    = 4,
    parameter int BUBBLE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Stall_E,
    input  logic                    Flush_E,
    input  logic                    Valid_D,
    input  logic [XLEN-1:0]         PC_D,
    input  logic [XLEN-1:0]         PCPlus4_D,
    input  logic [XLEN-1:0]         RD1_D,
    input  logic [XLEN-1:0]         RD2_D,
    input  logic [XLEN-1:0]         ImmExt_D,
    input  logic [4:0]              Rs1_D,
    input  logic [4:0]              Rs2_D,
    input  logic [4:0]              Rd_D,
    input  logic                    RegWrite_D,
    input  logic [1:0]              ResultSrc_D,
    input  logic                    MemWrite_D,
    input  logic                    MemRead_D,
    input  logic                    Branch_D,
    input  logic                    Jump_D,
    input  logic                    ALUSrc_D,
    input  logic [ALUCTRL_W-1:0]    ALUControl_D,
    input  logic                    Word_D,
    input  logic [2:0]              Funct3_D,
    output logic                    Valid_E,
    output logic [XLEN-1:0]         PC_E,
    output logic [XLEN-1:0]         PCPlus4_E,
    output logic [XLEN-1:0]         RD1_E,
    output logic [XLEN-1:0]         RD2_E,
    output logic [XLEN-1:0]         ImmExt_E,
    output logic [4:0]              Rs1_E,
    output logic [4:0]              Rs2_E,
    output logic [4:0]              Rd_E,
    output logic                    RegWrite_E,
    output logic [1:0]              ResultSrc_E,
    output logic                    MemWrite_E,
    output logic                    MemRead_E,
    output logic                    Branch_E,
    output logic                    Jump_E,
    output logic                    ALUSrc_E,
    output logic [ALUCTRL_W-1:0]    ALUControl_E,
    output logic                    Word_E,
    output logic [2:0]              Funct3_E,
    output logic [BUBBLE_CNT_W-1:0] BubbleCount
);

    import core_pkg::*;

    localparam int c_DATA_W = 5 * XLEN;
    localparam int c_IDX_W  = 15;

    // A bubble enters E on flush, or on a load of an invalid decode slot.
    // A stall without flush holds everything, including the counter.
    logic w_bubble;
    logic w_load;
    assign w_bubble = Flush_E | (~Stall_E & ~Valid_D);
    assign w_load   = ~Stall_E;

    logic [c_DATA_W-1:0] w_data_d;
    logic [c_DATA_W-1:0] w_data_e;
    logic [c_IDX_W-1:0]  w_idx_d;
    logic [c_IDX_W-1:0]  w_idx_e;
    ctrl_t               w_ctrl_d;
    ctrl_t               w_ctrl_e;

    assign w_data_d = {PC_D, PCPlus4_D, RD1_D, RD2_D, ImmExt_D};
    assign w_idx_d  = {Rs1_D, Rs2_D, Rd_D};

    // Pack the decoded control bits into the shared control word
    always_comb begin
        w_ctrl_d            = CTRL_BUBBLE;
        w_ctrl_d.reg_write  = RegWrite_D;
        w_ctrl_d.result_src = ResultSrc_D;
        w_ctrl_d.mem_write  = MemWrite_D;
        w_ctrl_d.mem_read   = MemRead_D;
        w_ctrl_d.branch     = Branch_D;
        w_ctrl_d.jump       = Jump_D;
        w_ctrl_d.alu_src    = ALUSrc_D;
        w_ctrl_d.alu_ctrl   = alu_ctrl_e'(ALUControl_D);
        w_ctrl_d.word       = Word_D;
        w_ctrl_d.funct3     = Funct3_D;
    end

    pipe_field_reg #(.WIDTH(1)) u_valid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_bubble),
        .i_en    (w_load),
        .i_d     (Valid_D),
        .o_q     (Valid_E)
    );

    pipe_field_reg #(.WIDTH(c_DATA_W)) u_data_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_bubble),
        .i_en    (w_load),
        .i_d     (w_data_d),
        .o_q     (w_data_e)
    );

    // Zeroed indices make a bubble look like x0, which forwarding ignores
    pipe_field_reg #(.WIDTH(c_IDX_W)) u_idx_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_bubble),
        .i_en    (w_load),
        .i_d     (w_idx_d),
        .o_q     (w_idx_e)
    );

    pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_bubble),
        .i_en    (w_load),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_e)
    );

    assign {PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E} = w_data_e;
    assign {Rs1_E, Rs2_E, Rd_E}                      = w_idx_e;

    assign RegWrite_E   = w_ctrl_e.reg_write;
    assign ResultSrc_E  = w_ctrl_e.result_src;
    assign MemWrite_E   = w_ctrl_e.mem_write;
    assign MemRead_E    = w_ctrl_e.mem_read;
    assign Branch_E     = w_ctrl_e.branch;
    assign Jump_E       = w_ctrl_e.jump;
    assign ALUSrc_E     = w_ctrl_e.alu_src;
    assign ALUControl_E = w_ctrl_e.alu_ctrl;
    assign Word_E       = w_ctrl_e.word;
    assign Funct3_E     = w_ctrl_e.funct3;

    logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

    // Saturating bubble counter; sticks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + BUBBLE_CNT_W'(1);
        end
    end

    assign BubbleCount = r_bubble_cnt;

endmodule : id_ex_pipe_reg
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Self-checking bench for id_ex_pipe_reg. Directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a field-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        memread;
        logic        branch;
        logic        jump;
        logic        alusrc;
        logic [3:0]  aluctrl;
        logic        word;
        logic [2:0]  funct3;
    } fields_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    stall;
    logic    flush;
    fields_t d;
    fields_t q;
    logic [CNT_W-1:0] bubble_cnt;

    // Reference model state
    fields_t m;
    int      m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .XLEN         (64),
        .ALUCTRL_W    (4),
        .BUBBLE_CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Stall_E      (stall),
        .Flush_E      (flush),
        .Valid_D      (d.valid),
        .PC_D         (d.pc),
        .PCPlus4_D    (d.pc4),
        .RD1_D        (d.rd1),
        .RD2_D        (d.rd2),
        .ImmExt_D     (d.imm),
        .Rs1_D        (d.rs1),
        .Rs2_D        (d.rs2),
        .Rd_D         (d.rd),
        .RegWrite_D   (d.regwrite),
        .ResultSrc_D  (d.resultsrc),
        .MemWrite_D   (d.memwrite),
        .MemRead_D    (d.memread),
        .Branch_D     (d.branch),
        .Jump_D       (d.jump),
        .ALUSrc_D     (d.alusrc),
        .ALUControl_D (d.aluctrl),
        .Word_D       (d.word),
        .Funct3_D     (d.funct3),
        .Valid_E      (q.valid),
        .PC_E         (q.pc),
        .PCPlus4_E    (q.pc4),
        .RD1_E        (q.rd1),
        .RD2_E        (q.rd2),
        .ImmExt_E     (q.imm),
        .Rs1_E        (q.rs1),
        .Rs2_E        (q.rs2),
        .Rd_E         (q.rd),
        .RegWrite_E   (q.regwrite),
        .ResultSrc_E  (q.resultsrc),
        .MemWrite_E   (q.memwrite),
        .MemRead_E    (q.memread),
        .Branch_E     (q.branch),
        .Jump_E       (q.jump),
        .ALUSrc_E     (q.alusrc),
        .ALUControl_E (q.aluctrl),
        .Word_E       (q.word),
        .Funct3_E     (q.funct3),
        .BubbleCount  (bubble_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rules: reset clears all; a bubble (flush, or load of invalid slot)
    // clears all and bumps the saturating count; stall holds; else copy D.
    task automatic model_step();
        if (rst) begin
            m     = '0;
            m_cnt = 0;
        end else if (flush || (!stall && !d.valid)) begin
            m = '0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (!stall) begin
            m = d;
        end
    endtask

    task automatic check_all();
        check_eq("valid",      q.valid,      m.valid);
        check_eq("pc",         q.pc,         m.pc);
        check_eq("pc4",        q.pc4,        m.pc4);
        check_eq("rd1",        q.rd1,        m.rd1);
        check_eq("rd2",        q.rd2,        m.rd2);
        check_eq("imm",        q.imm,        m.imm);
        check_eq("rs1",        q.rs1,        m.rs1);
        check_eq("rs2",        q.rs2,        m.rs2);
        check_eq("rd",         q.rd,         m.rd);
        check_eq("regwrite",   q.regwrite,   m.regwrite);
        check_eq("resultsrc",  q.resultsrc,  m.resultsrc);
        check_eq("memwrite",   q.memwrite,   m.memwrite);
        check_eq("memread",    q.memread,    m.memread);
        check_eq("branch",     q.branch,     m.branch);
        check_eq("jump",       q.jump,       m.jump);
        check_eq("alusrc",     q.alusrc,     m.alusrc);
        check_eq("aluctrl",    q.aluctrl,    m.aluctrl);
        check_eq("word",       q.word,       m.word);
        check_eq("funct3",     q.funct3,     m.funct3);
        check_eq("bubble_cnt", bubble_cnt,   m_cnt);
        if (!q.valid)
            check_eq("inert_bubble",
                     {q.regwrite, q.memwrite, q.memread, q.branch, q.jump, q.rd}, 0);
    endtask

    // Inputs are applied before this call; advance one edge and check
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_d(input bit force_valid);
        d.valid     = force_valid ? 1'b1 : (($urandom % 4) != 0);
        d.pc        = {$urandom, $urandom};
        d.pc4       = d.pc + 64'd4;
        d.rd1       = {$urandom, $urandom};
        d.rd2       = {$urandom, $urandom};
        d.imm       = {$urandom, $urandom};
        d.rs1       = 5'($urandom);
        d.rs2       = 5'($urandom);
        d.rd        = 5'($urandom);
        d.regwrite  = 1'($urandom);
        d.resultsrc = 2'($urandom_range(0, 2));
        d.memwrite  = 1'($urandom);
        d.memread   = 1'($urandom);
        d.branch    = 1'($urandom);
        d.jump      = 1'($urandom);
        d.alusrc    = 1'($urandom);
        d.aluctrl   = 4'($urandom_range(0, 13));
        d.word      = 1'($urandom);
        d.funct3    = 3'($urandom);
    endtask

    initial begin
        m     = '0;
        m_cnt = 0;
        stall = 1'b0;
        flush = 1'b0;

        // Reset with random inputs for two cycles
        rst = 1'b1;
        rand_d(1'b1);
        cycle();
        rand_d(1'b1);
        cycle();
        check_eq("rst_valid", q.valid, 0);
        check_eq("rst_cnt", bubble_cnt, 0);

        // Reset beats flush; counter must not move
        flush = 1'b1;
        cycle();
        check_eq("rst_flush_cnt", bubble_cnt, 0);
        rst   = 1'b0;
        flush = 1'b0;

        // Normal flow
        rand_d(1'b1);
        d.rs1 = 5'd5; d.rs2 = 5'd6; d.rd = 5'd7;
        d.rd1 = 64'hDEAD_BEEF_0000_0001; d.regwrite = 1'b1;
        cycle();
        check_eq("flow_rs1", q.rs1, 5);
        check_eq("flow_rs2", q.rs2, 6);
        check_eq("flow_rd", q.rd, 7);
        check_eq("flow_rd1", q.rd1, 64'hDEAD_BEEF_0000_0001);
        check_eq("flow_valid", q.valid, 1);

        // Stall holds for three cycles, releases on the first free edge
        d.rd = 5'd9;
        cycle();
        check_eq("stall_load_rd", q.rd, 9);
        stall = 1'b1;
        d.rd  = 5'd12;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_hold_rd", q.rd, 9);
            check_eq("stall_hold_cnt", bubble_cnt, 0);
        end
        stall = 1'b0;
        cycle();
        check_eq("stall_release_rd", q.rd, 12);

        // Flush beats stall
        stall = 1'b1; flush = 1'b1; d.memwrite = 1'b1;
        cycle();
        check_eq("flush_valid", q.valid, 0);
        check_eq("flush_memwrite", q.memwrite, 0);
        check_eq("flush_idx", {q.rs1, q.rs2, q.rd}, 0);
        check_eq("flush_cnt", bubble_cnt, 1);
        stall = 1'b0; flush = 1'b0;

        // Invalid decode slot becomes a bubble
        d.valid = 1'b0; d.regwrite = 1'b1; d.rd = 5'd3;
        cycle();
        check_eq("inval_regwrite", q.regwrite, 0);
        check_eq("inval_rd", q.rd, 0);
        check_eq("inval_cnt", bubble_cnt, 2);

        // Saturation after 20 consecutive flushes
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_d(1'b0);
            cycle();
        end
        check_eq("sat_cnt", bubble_cnt, CNT_MAX);
        flush = 1'b0;

        // Randomized traffic, with occasional mid-stream reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rand_d(1'b0);
            stall = (($urandom % 4) == 0);
            flush = (($urandom % 6) == 0);
            rst   = (($urandom % 60) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_id_ex_pipe_reg
`default_nettype wire
